fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that lets N_REQ producers share the single write port of a `fifo_synchronous` instance. It picks one requester per beat, or per burst when burst hold is enabled. It drives the FIFO's `w_en`/`data_in` and stalls every producer while the FIFO reports `full`. It sits between the producer blocks and the FIFO, in the FIFO's clock domain.

---
 rtl/fifo_wr_arb_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package fifo_wr_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   // Modulo increment with an explicit wrap, so n need not be a power of two.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set bit of req at or above ptr, wrapping at N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      int pos;
      found = 1'b0;
      idx   = '0;
      // Walk from lowest priority down to ptr so the last hit is the winner.
      for (int k = N - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         if (req[pos]) begin
            found = 1'b1;
            idx   = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Optional burst hold is enabled by defining FIFO_WR_ARB_BURST_EN.
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 8,
   parameter int BURST_LEN = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*WIDTH-1:0]     req_data,
   output logic [N_REQ-1:0]           req_ready,
   input  logic                       fifo_full,
   output logic                       fifo_w_en,
   output logic [WIDTH-1:0]           fifo_data_in,
   output logic                       grant_valid,
   output logic [$clog2(N_REQ)-1:0]   grant_id
);

   localparam int ID_W = $clog2(N_REQ);

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  rr_ptr_nxt;
   logic             pick_found;
   logic [ID_W-1:0]  pick_idx;
   logic             sel_valid;
   logic [ID_W-1:0]  sel_id;
   logic [WIDTH-1:0] req_slice [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_slice
      assign req_slice[g] = req_data[g*WIDTH +: WIDTH];
   end

   rr_pick #(
      .N  (N_REQ),
      .IW (ID_W)
   ) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

`ifdef FIFO_WR_ARB_BURST_EN
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [ID_W-1:0]  owner;
   logic [ID_W-1:0]  owner_nxt;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] beat_cnt_nxt;

   // A HOLD owner that drops valid gets no grant; the release costs one bubble.
   always_comb begin
      if (state == HOLD) begin
         sel_valid = req_valid[owner];
         sel_id    = owner;
      end else begin
         sel_valid = pick_found;
         sel_id    = pick_idx;
      end
   end
`else
   always_comb begin
      sel_valid = pick_found;
      sel_id    = pick_idx;
   end
`endif

   // Outputs are forced to zero while rst is high, independent of the clock.
   always_comb begin
      grant_valid  = sel_valid & ~rst;
      grant_id     = grant_valid ? sel_id : '0;
      fifo_w_en    = grant_valid & ~fifo_full;
      fifo_data_in = grant_valid ? req_slice[grant_id] : '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = fifo_w_en & (grant_id == ID_W'(i));
      end
   end

`ifdef FIFO_WR_ARB_BURST_EN
   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      beat_cnt_nxt = beat_cnt;
      rr_ptr_nxt   = rr_ptr;
      case (state)
         IDLE: begin
            if (fifo_w_en) begin
               if (BURST_LEN > 1) begin
                  state_nxt    = HOLD;
                  owner_nxt    = grant_id;
                  beat_cnt_nxt = CNT_W'(1);
               end else begin
                  rr_ptr_nxt = ID_W'(rr_next(int'(grant_id), N_REQ));
               end
            end
         end
         HOLD: begin
            // A full FIFO blocks fifo_w_en, so the count and ownership freeze.
            if (!req_valid[owner] ||
                (fifo_w_en && (int'(beat_cnt) + 1 == BURST_LEN))) begin
               state_nxt    = IDLE;
               beat_cnt_nxt = '0;
               rr_ptr_nxt   = ID_W'(rr_next(int'(owner), N_REQ));
            end else if (fifo_w_en) begin
               beat_cnt_nxt = beat_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         state    <= IDLE;
         owner    <= '0;
         beat_cnt <= '0;
      end else begin
         rr_ptr   <= rr_ptr_nxt;
         state    <= state_nxt;
         owner    <= owner_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end
`else
   always_comb begin
      rr_ptr_nxt = rr_ptr;
      if (fifo_w_en) rr_ptr_nxt = ID_W'(rr_next(int'(grant_id), N_REQ));
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_ptr <= '0;
      else     rr_ptr <= rr_ptr_nxt;
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter; burst scenarios run when FIFO_WR_ARB_BURST_EN is defined.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int BL = 4;

   // Packed observation: {grant_valid, grant_id, fifo_w_en, req_ready, fifo_data_in}
   typedef logic [15:0] obs_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           fifo_full;
   logic           fifo_w_en;
   logic [W-1:0]   fifo_data_in;
   logic           grant_valid;
   logic [1:0]     grant_id;

   logic [W-1:0]   data_tab [N];
   obs_t           exp_q [$];
   int             passed = 0;
   int             total  = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .N_REQ     (N),
      .WIDTH     (W),
      .BURST_LEN (BL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_w_en    (fifo_w_en),
      .fifo_data_in (fifo_data_in),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id)
   );

   function automatic obs_t mk_exp(input bit gv, input int id, input bit wen);
      logic [N-1:0] rdy;
      logic [W-1:0] d;
      logic [1:0]   idv;
      idv = gv ? 2'(id) : 2'd0;
      rdy = wen ? (N'(1) << id) : '0;
      d   = gv ? data_tab[id] : '0;
      return {gv, idv, wen, rdy, d};
   endfunction

   function automatic obs_t observe();
      return {grant_valid, grant_id, fifo_w_en, req_ready, fifo_data_in};
   endfunction

   task automatic load_data(input logic [7:0] base);
      for (int i = 0; i < N; i++) begin
         data_tab[i] = base + 8'(i * 17);
         req_data[i*W +: W] = data_tab[i];
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      fifo_full = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      obs_t got, want;
      rst = 1'b1;
      fifo_full = 1'b0;
      req_valid = 4'hF;
      load_data(8'h30);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(mk_exp(0, 0, 0));
         #2;
         got = observe();
         want = exp_q.pop_front();
         total++;
         if (got !== want)
            $display("FAIL reset_outputs %0d: got {gv,id,wen,ready,data}=%h want %h", k, got, want);
         else passed++;
         @(negedge clk);
      end
      rst = 1'b0;
   endtask

   task automatic test_rotation();
      obs_t got, want;
      load_data(8'h10);
      fifo_full = 1'b0;
      for (int k = 0; k < 5; k++) exp_q.push_back(mk_exp(1, k % N, 1));
      req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         #2;
         got = observe();
         want = exp_q.pop_front();
         total++;
         if (got !== want)
            $display("FAIL rotation beat %0d: got {gv,id,wen,ready,data}=%h want %h", k, got, want);
         else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_wrap();
      obs_t got, want;
      logic [N-1:0] vtab [2];
      vtab[0] = 4'b0100;
      vtab[1] = 4'b0101;
      load_data(8'h41);
      exp_q.push_back(mk_exp(1, 2, 1));
      exp_q.push_back(mk_exp(1, 0, 1));
      for (int k = 0; k < 2; k++) begin
         req_valid = vtab[k];
         #2;
         got = observe();
         want = exp_q.pop_front();
         total++;
         if (got !== want)
            $display("FAIL wrap step %0d: got {gv,id,wen,ready,data}=%h want %h", k, got, want);
         else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_full_stall();
      obs_t got, want;
      logic ftab [4];
      ftab[0] = 1'b1; ftab[1] = 1'b1; ftab[2] = 1'b1; ftab[3] = 1'b0;
      load_data(8'h77);
      for (int k = 0; k < 3; k++) exp_q.push_back(mk_exp(1, 1, 0));
      exp_q.push_back(mk_exp(1, 1, 1));
      req_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         fifo_full = ftab[k];
         #2;
         got = observe();
         want = exp_q.pop_front();
         total++;
         if (got !== want)
            $display("FAIL full_stall cycle %0d: got {gv,id,wen,ready,data}=%h want %h", k, got, want);
         else passed++;
         @(negedge clk);
      end
      fifo_full = 1'b0;
   endtask

`ifdef FIFO_WR_ARB_BURST_EN
   task automatic test_burst_switch();
      obs_t got, want;
      do_reset();
      load_data(8'h05);
      for (int k = 0; k < 2 * BL; k++) exp_q.push_back(mk_exp(1, (k < BL) ? 0 : 1, 1));
      req_valid = 4'b0011;
      for (int k = 0; k < 2 * BL; k++) begin
         #2;
         got = observe();
         want = exp_q.pop_front();
         total++;
         if (got !== want)
            $display("FAIL burst_switch beat %0d: got {gv,id,wen,ready,data}=%h want %h", k, got, want);
         else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_burst_drop();
      obs_t got, want;
      logic [N-1:0] vtab [4];
      vtab[0] = 4'b1100; vtab[1] = 4'b1100; vtab[2] = 4'b1000; vtab[3] = 4'b1000;
      load_data(8'h92);
      exp_q.push_back(mk_exp(1, 2, 1));
      exp_q.push_back(mk_exp(1, 2, 1));
      exp_q.push_back(mk_exp(0, 0, 0));
      exp_q.push_back(mk_exp(1, 3, 1));
      for (int k = 0; k < 4; k++) begin
         req_valid = vtab[k];
         #2;
         got = observe();
         want = exp_q.pop_front();
         total++;
         if (got !== want)
            $display("FAIL burst_drop cycle %0d: got {gv,id,wen,ready,data}=%h want %h", k, got, want);
         else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_full_in_hold();
      obs_t got, want;
      logic ftab [6];
      ftab[0] = 1'b1; ftab[1] = 1'b1;
      for (int k = 2; k < 6; k++) ftab[k] = 1'b0;
      load_data(8'hC3);
      exp_q.push_back(mk_exp(1, 3, 0));
      exp_q.push_back(mk_exp(1, 3, 0));
      for (int k = 0; k < 3; k++) exp_q.push_back(mk_exp(1, 3, 1));
      exp_q.push_back(mk_exp(1, 0, 1));
      req_valid = 4'b1001;
      for (int k = 0; k < 6; k++) begin
         fifo_full = ftab[k];
         #2;
         got = observe();
         want = exp_q.pop_front();
         total++;
         if (got !== want)
            $display("FAIL full_in_hold cycle %0d: got {gv,id,wen,ready,data}=%h want %h", k, got, want);
         else passed++;
         @(negedge clk);
      end
      fifo_full = 1'b0;
   endtask
`endif

   task automatic test_async_reset();
      obs_t got, want;
      load_data(8'h5A);
`ifdef FIFO_WR_ARB_BURST_EN
      exp_q.push_back(mk_exp(0, 0, 0));
      exp_q.push_back(mk_exp(1, 1, 1));
`else
      exp_q.push_back(mk_exp(1, 2, 1));
      exp_q.push_back(mk_exp(1, 1, 1));
`endif
      req_valid = 4'b0110;
      for (int k = 0; k < 2; k++) begin
         #2;
         got = observe();
         want = exp_q.pop_front();
         total++;
         if (got !== want)
            $display("FAIL async_pre cycle %0d: got {gv,id,wen,ready,data}=%h want %h", k, got, want);
         else passed++;
         @(negedge clk);
      end
      // Assert reset mid-cycle, away from any clock edge.
      #2 rst = 1'b1;
      exp_q.push_back(mk_exp(0, 0, 0));
      #1;
      got = observe();
      want = exp_q.pop_front();
      total++;
      if (got !== want)
         $display("FAIL async_assert: got {gv,id,wen,ready,data}=%h want %h", got, want);
      else passed++;
      @(posedge clk);
      exp_q.push_back(mk_exp(0, 0, 0));
      #1;
      got = observe();
      want = exp_q.pop_front();
      total++;
      if (got !== want)
         $display("FAIL async_held: got {gv,id,wen,ready,data}=%h want %h", got, want);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      req_valid = 4'b0111;
      exp_q.push_back(mk_exp(1, 0, 1));
      #2;
      got = observe();
      want = exp_q.pop_front();
      total++;
      if (got !== want)
         $display("FAIL async_first_grant: got {gv,id,wen,ready,data}=%h want %h", got, want);
      else passed++;
      @(negedge clk);
      req_valid = '0;
   endtask

   initial begin
      test_reset();
`ifdef FIFO_WR_ARB_BURST_EN
      test_full_stall();
      test_burst_switch();
      test_burst_drop();
      test_full_in_hold();
`else
      test_rotation();
      test_wrap();
      test_full_stall();
`endif
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
